// File: rtl/udp_rx_filter.sv
// Byte-stream Ethernet II / IPv4 / UDP receive filter. Forwards only the UDP payload
// of frames addressed to local_ip (and DST_PORT when non-zero), and counts the rest.
module udp_rx_filter #(
    parameter logic [15:0] DST_PORT  = 16'h0000,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  eth_din,
    input  logic        eth_din_en,
    input  logic [31:0] local_ip,
    output logic [7:0]  udp_dout,
    output logic        udp_dout_en,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_drop_cnt
);

    localparam int unsigned CW = 11;

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DISCARD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [15:0]     rem;
    logic [7:0]      len_hi;
    logic [23:0]     ip_hi;
    logic            drop_pend;
    logic            en_q;
    logic            hdr_bad;
    logic            at_limit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign at_limit = (cnt == CW'(MAX_FRAME));

    // Per-byte header field check, keyed on the byte index of the current input byte
    always_comb begin
        hdr_bad = 1'b0;
        case (cnt)
            11'd12: hdr_bad = (eth_din != 8'h08);
            11'd13: hdr_bad = (eth_din != 8'h00);
            11'd14: hdr_bad = (eth_din != 8'h45);
            11'd20: hdr_bad = (eth_din[5:0] != 6'd0);
            11'd21: hdr_bad = (eth_din != 8'h00);
            11'd23: hdr_bad = (eth_din != 8'd17);
            11'd33: hdr_bad = ({ip_hi, eth_din} != local_ip);
            11'd36: hdr_bad = (DST_PORT != 16'd0) && (eth_din != DST_PORT[15:8]);
            11'd37: hdr_bad = (DST_PORT != 16'd0) && (eth_din != DST_PORT[7:0]);
            11'd39: hdr_bad = ({len_hi, eth_din} < 16'd8);
            default: hdr_bad = 1'b0;
        endcase
    end

    // en_q resets high so a frame interrupted by reset is skipped until its end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            rem            <= '0;
            len_hi         <= '0;
            ip_hi          <= '0;
            drop_pend      <= 1'b0;
            en_q           <= 1'b1;
            udp_dout       <= '0;
            udp_dout_en    <= 1'b0;
            frame_ok_cnt   <= '0;
            frame_drop_cnt <= '0;
        end else begin
            en_q <= eth_din_en;
            if (eth_din_en && state != IDLE && cnt != '1)
                cnt <= cnt + CW'(1);

            case (state)
                IDLE: begin
                    udp_dout_en <= 1'b0;
                    drop_pend   <= 1'b0;
                    cnt         <= '0;
                    if (eth_din_en && !en_q) begin
                        cnt   <= CW'(1);
                        state <= HDR;
                    end
                end
                HDR: begin
                    udp_dout_en <= 1'b0;
                    if (!eth_din_en) begin
                        frame_drop_cnt <= sat_inc(frame_drop_cnt);
                        cnt            <= '0;
                        state          <= IDLE;
                    end else if (at_limit) begin
                        frame_drop_cnt <= sat_inc(frame_drop_cnt);
                        drop_pend      <= 1'b0;
                        state          <= DISCARD;
                    end else if (hdr_bad) begin
                        drop_pend <= 1'b1;
                        state     <= DISCARD;
                    end else begin
                        case (cnt)
                            11'd30: ip_hi[23:16] <= eth_din;
                            11'd31: ip_hi[15:8]  <= eth_din;
                            11'd32: ip_hi[7:0]   <= eth_din;
                            11'd38: len_hi       <= eth_din;
                            11'd39: rem          <= {len_hi, eth_din} - 16'd8;
                            11'd41: begin
                                if (rem == 16'd0) begin
                                    frame_ok_cnt <= sat_inc(frame_ok_cnt);
                                    drop_pend    <= 1'b0;
                                    state        <= DISCARD;
                                end else begin
                                    state <= PAYLOAD;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (!eth_din_en) begin
                        udp_dout_en    <= 1'b0;
                        frame_drop_cnt <= sat_inc(frame_drop_cnt);
                        cnt            <= '0;
                        state          <= IDLE;
                    end else if (at_limit) begin
                        udp_dout_en    <= 1'b0;
                        frame_drop_cnt <= sat_inc(frame_drop_cnt);
                        drop_pend      <= 1'b0;
                        state          <= DISCARD;
                    end else begin
                        udp_dout    <= eth_din;
                        udp_dout_en <= 1'b1;
                        rem         <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            frame_ok_cnt <= sat_inc(frame_ok_cnt);
                            drop_pend    <= 1'b0;
                            state        <= DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    udp_dout_en <= 1'b0;
                    if (!eth_din_en) begin
                        if (drop_pend)
                            frame_drop_cnt <= sat_inc(frame_drop_cnt);
                        drop_pend <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_rx_filter.sv
// Bench for udp_rx_filter: frame-level model predicts every output cycle and the
// counters; directed frames cover acceptance, each reject reason, padding, truncation, reset.
module tb_udp_rx_filter;

    localparam logic [15:0] PORT = 16'd1234;
    localparam int          MAXF = 1518;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  eth_din = 8'h00;
    logic        eth_din_en = 1'b0;
    logic [31:0] local_ip = 32'hC0A8_0102;
    logic [7:0]  udp_dout;
    logic        udp_dout_en;
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_drop_cnt;

    udp_rx_filter #(.DST_PORT(PORT), .MAX_FRAME(MAXF)) dut (
        .clk(clk), .rst(rst), .eth_din(eth_din), .eth_din_en(eth_din_en),
        .local_ip(local_ip), .udp_dout(udp_dout), .udp_dout_en(udp_dout_en),
        .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] frm [0:2047];
    logic       exp_en = 1'b0;
    logic [7:0] exp_last = 8'h00;
    int         exp_ok = 0;
    int         exp_drop = 0;

    int         cur_k = 0;
    int         en_cycles = 0;
    int         first_k = -1;
    logic [7:0] first_byte = 8'h00;
    bit         seen = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Cycle compare: output reflects the byte driven before the preceding rising edge
    initial begin
        forever begin
            @(posedge clk);
            #2;
            chk("dout_en", int'(udp_dout_en), int'(exp_en));
            chk("dout", int'(udp_dout), int'(exp_last));
            if (udp_dout_en) begin
                en_cycles++;
                if (!seen) begin
                    seen       = 1'b1;
                    first_k    = cur_k;
                    first_byte = udp_dout;
                end
            end
        end
    end

    task automatic build(input logic [31:0] dip, input logic [15:0] dport, input logic [15:0] ulen,
                         input logic [7:0] proto, input logic [7:0] b20, input logic [15:0] etype);
        for (int i = 0; i < 2048; i++) frm[i] = 8'(i * 7 + 3);
        frm[12] = etype[15:8]; frm[13] = etype[7:0];
        frm[14] = 8'h45;       frm[20] = b20;   frm[21] = 8'h00;
        frm[22] = 8'd64;       frm[23] = proto;
        frm[30] = dip[31:24];  frm[31] = dip[23:16]; frm[32] = dip[15:8]; frm[33] = dip[7:0];
        frm[36] = dport[15:8]; frm[37] = dport[7:0];
        frm[38] = ulen[15:8];  frm[39] = ulen[7:0];
        frm[42] = 8'h47;
    endtask

    function automatic bit hdr_good();
        logic [15:0] l;
        logic [7:0]  f20;
        l   = {frm[38], frm[39]};
        f20 = frm[20];
        return frm[12] == 8'h08 && frm[13] == 8'h00 && frm[14] == 8'h45 &&
               f20[5:0] == 6'd0 && frm[21] == 8'h00 && frm[23] == 8'd17 &&
               {frm[30], frm[31], frm[32], frm[33]} == local_ip &&
               (PORT == 16'd0 || {frm[36], frm[37]} == PORT) && l >= 16'd8;
    endfunction

    // Drive flen bytes of frm; rst_at >= 0 asserts reset while that byte is on the bus
    task automatic send(input int flen, input int rst_at);
        int len;
        bit good;
        bit killed;
        len    = int'({frm[38], frm[39]});
        good   = hdr_good();
        killed = 1'b0;
        en_cycles = 0;
        seen      = 1'b0;
        first_k   = -1;
        for (int k = 0; k < flen; k++) begin
            @(negedge clk);
            if (k == rst_at) begin
                rst = 1'b1; killed = 1'b1;
                exp_ok = 0; exp_drop = 0; exp_last = 8'h00;
            end
            if (rst_at >= 0 && k == rst_at + 2) rst = 1'b0;
            eth_din    = frm[k];
            eth_din_en = 1'b1;
            cur_k      = k;
            exp_en = !killed && good && flen >= 42 && k >= 42 && k < 34 + len && k < MAXF;
            if (exp_en) exp_last = frm[k];
            if (k == rst_at) begin
                #1;
                chk("rst_en", int'(udp_dout_en), 0);
                chk("rst_ok_cnt", int'(frame_ok_cnt), 0);
                chk("rst_drop_cnt", int'(frame_drop_cnt), 0);
            end
        end
        @(negedge clk);
        eth_din_en = 1'b0;
        exp_en     = 1'b0;
        if (!killed) begin
            if (good && 34 + len <= flen && 34 + len <= MAXF) exp_ok++;
            else exp_drop++;
        end
        repeat (3) @(negedge clk);
        chk("ok_cnt", int'(frame_ok_cnt), exp_ok);
        chk("drop_cnt", int'(frame_drop_cnt), exp_drop);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ok", int'(frame_ok_cnt), 0);
        chk("reset_drop", int'(frame_drop_cnt), 0);
        chk("reset_en", int'(udp_dout_en), 0);
        chk("reset_dout", int'(udp_dout), 0);

        // valid 188-byte TS payload
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h00, 16'h0800);
        send(230, -1);
        chk("t1_bytes", en_cycles, 188);
        chk("t1_first_byte", int'(first_byte), 8'h47);
        chk("t1_first_k", first_k, 42);
        chk("t1_ok", int'(frame_ok_cnt), 1);

        // wrong destination IP
        build(32'hC0A8_0103, PORT, 16'd196, 8'd17, 8'h00, 16'h0800);
        send(230, -1);
        chk("t2_bytes", en_cycles, 0);
        chk("t2_drop", int'(frame_drop_cnt), 1);
        chk("t2_ok", int'(frame_ok_cnt), 1);

        // short UDP length inside a padded 64-byte frame
        build(32'hC0A8_0102, PORT, 16'd12, 8'd17, 8'h00, 16'h0800);
        send(64, -1);
        chk("t3_bytes", en_cycles, 4);
        chk("t3_ok", int'(frame_ok_cnt), 2);

        // frame ends after 100 payload bytes, then a good frame
        build(32'hC0A8_0102, PORT, 16'd1324, 8'd17, 8'h00, 16'h0800);
        send(142, -1);
        chk("t4_bytes", en_cycles, 100);
        chk("t4_drop", int'(frame_drop_cnt), 2);
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h00, 16'h0800);
        send(230, -1);
        chk("t4_next_bytes", en_cycles, 188);
        chk("t4_next_ok", int'(frame_ok_cnt), 3);

        // TCP, MF set
        build(32'hC0A8_0102, PORT, 16'd196, 8'd6, 8'h00, 16'h0800);
        send(230, -1);
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h20, 16'h0800);
        send(230, -1);
        chk("t5_drop", int'(frame_drop_cnt), 4);

        // other reject reasons and boundary cases
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h00, 16'h0806);
        send(230, -1);
        build(32'hC0A8_0102, 16'd80, 16'd196, 8'd17, 8'h00, 16'h0800);
        send(230, -1);
        build(32'hC0A8_0102, PORT, 16'd7, 8'd17, 8'h00, 16'h0800);
        send(60, -1);
        build(32'hC0A8_0102, PORT, 16'd8, 8'd17, 8'h00, 16'h0800);
        send(60, -1);
        chk("len8_bytes", en_cycles, 0);
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h01, 16'h0800);
        send(230, -1);
        build(32'hC0A8_0102, PORT, 16'd40, 8'd17, 8'h40, 16'h0800);
        send(90, -1);
        chk("df_bytes", en_cycles, 32);
        chk("misc_ok", int'(frame_ok_cnt), 5);
        chk("misc_drop", int'(frame_drop_cnt), 8);

        // oversize frame truncated at the length limit
        build(32'hC0A8_0102, PORT, 16'd1500, 8'd17, 8'h00, 16'h0800);
        send(1530, -1);
        chk("trunc_bytes", en_cycles, 1476);
        chk("trunc_drop", int'(frame_drop_cnt), 9);

        // reset at payload byte 50, then a clean frame
        build(32'hC0A8_0102, PORT, 16'd196, 8'd17, 8'h00, 16'h0800);
        send(230, 92);
        chk("t6_bytes", en_cycles, 50);
        chk("t6_ok", int'(frame_ok_cnt), 0);
        send(230, -1);
        chk("t6_next_bytes", en_cycles, 188);
        chk("t6_next_ok", int'(frame_ok_cnt), 1);
        chk("t6_next_drop", int'(frame_drop_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
